// File: rtl/bcd_counter_multi.sv
// Multi-digit BCD up/down counter with clear, load, wrap/saturate and a terminal-count pulse.
// Latency: all outputs registered, one clk edge after the controlling inputs.
// Backpressure: none; downstream stages chain by feeding done into their enable.
module bcd_counter_multi #(
    parameter int DIGITS = 4,
    parameter bit WRAP   = 1'b1
) (
    input  logic                  clk,
    input  logic                  reset,
    input  logic                  enable,
    input  logic                  up_dn,
    input  logic                  clear,
    input  logic                  load,
    input  logic [4*DIGITS-1:0]   load_val,
    output logic [4*DIGITS-1:0]   Q,
    output logic                  done,
    output logic                  load_err
);
    localparam int W = 4 * DIGITS;

    logic [W-1:0] step_val;
    logic [W-1:0] load_dat;
    logic         terminal;
    logic         load_bad;
    logic         carry;
    logic [3:0]   dig;
    logic [3:0]   ld_dig;

    // Ripple the step from digit 0 upward; a carry/borrow out of the top
    // digit means every digit sat at its end value, i.e. the terminal step.
    always_comb begin
        step_val = Q;
        carry    = 1'b1;
        dig      = 4'd0;
        for (int i = 0; i < DIGITS; i++) begin
            dig = Q[4*i +: 4];
            if (carry) begin
                if (up_dn) begin
                    if (dig == 4'd9) begin
                        step_val[4*i +: 4] = 4'd0;
                    end else begin
                        step_val[4*i +: 4] = dig + 4'd1;
                        carry              = 1'b0;
                    end
                end else begin
                    if (dig == 4'd0) begin
                        step_val[4*i +: 4] = 4'd9;
                    end else begin
                        step_val[4*i +: 4] = dig - 4'd1;
                        carry              = 1'b0;
                    end
                end
            end
        end
        terminal = carry;
    end

    // Non-BCD load digits are forced to zero so Q never leaves BCD.
    always_comb begin
        load_dat = '0;
        load_bad = 1'b0;
        ld_dig   = 4'd0;
        for (int i = 0; i < DIGITS; i++) begin
            ld_dig = load_val[4*i +: 4];
            if (ld_dig > 4'd9) begin
                load_bad = 1'b1;
            end else begin
                load_dat[4*i +: 4] = ld_dig;
            end
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            Q        <= '0;
            done     <= 1'b0;
            load_err <= 1'b0;
        end else begin
            done     <= 1'b0;
            load_err <= 1'b0;
            if (clear) begin
                Q <= '0;
            end else if (load) begin
                Q        <= load_dat;
                load_err <= load_bad;
            end else if (enable) begin
                done <= terminal;
                if (!terminal || WRAP) begin
                    Q <= step_val;
                end
            end
        end
    end

endmodule

// File: tb/tb_bcd_counter_multi.sv
// Bench for bcd_counter_multi: 2-digit wrap, 2-digit saturate and 4-digit wrap
// instances share stimulus and are compared against a decimal-integer model.
module tb_bcd_counter_multi;
    logic        clk = 1'b0;
    logic        reset, enable, up_dn, clear, load;
    logic [15:0] load_val;
    logic [7:0]  q_w2, q_s2;
    logic [15:0] q_w4;
    logic        done_w2, done_s2, done_w4;
    logic        err_w2, err_s2, err_w4;

    int m_w2, m_s2, m_w4;
    bit d_w2, d_s2, d_w4;
    bit e_w2, e_s2, e_w4;
    int checks = 0;
    int errors = 0;

    always #5 clk = ~clk;

    bcd_counter_multi #(.DIGITS(2), .WRAP(1'b1)) u_w2 (
        .clk(clk), .reset(reset), .enable(enable), .up_dn(up_dn), .clear(clear),
        .load(load), .load_val(load_val[7:0]), .Q(q_w2), .done(done_w2), .load_err(err_w2)
    );
    bcd_counter_multi #(.DIGITS(2), .WRAP(1'b0)) u_s2 (
        .clk(clk), .reset(reset), .enable(enable), .up_dn(up_dn), .clear(clear),
        .load(load), .load_val(load_val[7:0]), .Q(q_s2), .done(done_s2), .load_err(err_s2)
    );
    bcd_counter_multi #(.DIGITS(4), .WRAP(1'b1)) u_w4 (
        .clk(clk), .reset(reset), .enable(enable), .up_dn(up_dn), .clear(clear),
        .load(load), .load_val(load_val), .Q(q_w4), .done(done_w4), .load_err(err_w4)
    );

    function automatic logic [15:0] to_bcd(input int v);
        logic [15:0] r;
        int t;
        r = '0;
        t = v;
        for (int i = 0; i < 4; i++) begin
            r[4*i +: 4] = 4'(t % 10);
            t = t / 10;
        end
        return r;
    endfunction

    // Reference: the count is a plain integer in 0..10^digits-1.
    task automatic mstep(input int digits, input bit wrap, inout int v, inout bit dn, inout bit er);
        int maxv, p, lv;
        bit bad;
        int d;
        maxv = 1;
        for (int i = 0; i < digits; i++) maxv = maxv * 10;
        maxv = maxv - 1;
        if (clear) begin
            v = 0; dn = 0; er = 0;
        end else if (load) begin
            lv = 0; p = 1; bad = 0;
            for (int i = 0; i < digits; i++) begin
                d = int'(load_val[4*i +: 4]);
                if (d > 9) bad = 1;
                else lv = lv + d * p;
                p = p * 10;
            end
            v = lv; er = bad; dn = 0;
        end else if (enable) begin
            er = 0;
            if (up_dn) begin
                if (v == maxv) begin dn = 1; if (wrap) v = 0; end
                else begin dn = 0; v = v + 1; end
            end else begin
                if (v == 0) begin dn = 1; if (wrap) v = maxv; end
                else begin dn = 0; v = v - 1; end
            end
        end else begin
            dn = 0; er = 0;
        end
    endtask

    task automatic step();
        mstep(2, 1'b1, m_w2, d_w2, e_w2);
        mstep(2, 1'b0, m_s2, d_s2, e_s2);
        mstep(4, 1'b1, m_w4, d_w4, e_w4);
        @(posedge clk);
        #1;
    endtask

    task automatic zero_models();
        m_w2 = 0; m_s2 = 0; m_w4 = 0;
        d_w2 = 0; d_s2 = 0; d_w4 = 0;
        e_w2 = 0; e_s2 = 0; e_w4 = 0;
    endtask

    task automatic test_reset();
        reset = 1; enable = 0; up_dn = 1; clear = 0; load = 0; load_val = '0;
        zero_models();
        #100;
        checks++; if (q_w2 !== 8'h00) begin errors++; $display("FAIL reset_q_w2: got %h expected 00", q_w2); end
        checks++; if (q_s2 !== 8'h00) begin errors++; $display("FAIL reset_q_s2: got %h expected 00", q_s2); end
        checks++; if (q_w4 !== 16'h0000) begin errors++; $display("FAIL reset_q_w4: got %h expected 0000", q_w4); end
        checks++; if ({done_w2, done_s2, done_w4} !== 3'b000) begin errors++; $display("FAIL reset_done: got %b expected 000", {done_w2, done_s2, done_w4}); end
        checks++; if ({err_w2, err_s2, err_w4} !== 3'b000) begin errors++; $display("FAIL reset_err: got %b expected 000", {err_w2, err_s2, err_w4}); end
        reset = 0;
    endtask

    task automatic test_count_up();
        logic [15:0] e;
        enable = 1; up_dn = 1;
        for (int k = 1; k <= 100; k++) begin
            step();
            e = to_bcd(k % 100);
            checks++; if (q_w2 !== e[7:0]) begin errors++; $display("FAIL count_up_q step %0d: got %h expected %h", k, q_w2, e[7:0]); end
            checks++; if (done_w2 !== (k == 100)) begin errors++; $display("FAIL count_up_done step %0d: got %b expected %b", k, done_w2, (k == 100)); end
        end
        enable = 0;
    endtask

    task automatic test_load_down();
        logic [15:0] e;
        load = 1; load_val = 16'h0050;
        step();
        load = 0;
        checks++; if (q_w2 !== 8'h50) begin errors++; $display("FAIL load50_q: got %h expected 50", q_w2); end
        checks++; if (done_w2 !== 1'b0) begin errors++; $display("FAIL load50_done: got %b expected 0", done_w2); end
        enable = 1; up_dn = 0;
        for (int k = 1; k <= 51; k++) begin
            step();
            e = to_bcd((150 - k) % 100);
            checks++; if (q_w2 !== e[7:0]) begin errors++; $display("FAIL count_down_q step %0d: got %h expected %h", k, q_w2, e[7:0]); end
            checks++; if (done_w2 !== (k == 51)) begin errors++; $display("FAIL count_down_done step %0d: got %b expected %b", k, done_w2, (k == 51)); end
        end
        enable = 0;
    endtask

    task automatic test_saturate();
        load = 1; load_val = 16'h0098;
        step();
        load = 0;
        checks++; if (q_s2 !== 8'h98) begin errors++; $display("FAIL sat_load_q: got %h expected 98", q_s2); end
        enable = 1; up_dn = 1;
        for (int k = 1; k <= 3; k++) begin
            step();
            checks++; if (q_s2 !== 8'h99) begin errors++; $display("FAIL sat_up_q step %0d: got %h expected 99", k, q_s2); end
            checks++; if (done_s2 !== (k > 1)) begin errors++; $display("FAIL sat_up_done step %0d: got %b expected %b", k, done_s2, (k > 1)); end
        end
        enable = 0; clear = 1;
        step();
        clear = 0;
        checks++; if (q_s2 !== 8'h00 || done_s2 !== 1'b0) begin errors++; $display("FAIL sat_clear: got q=%h done=%b expected q=00 done=0", q_s2, done_s2); end
        enable = 1; up_dn = 0;
        for (int k = 1; k <= 2; k++) begin
            step();
            checks++; if (q_s2 !== 8'h00 || done_s2 !== 1'b1) begin errors++; $display("FAIL sat_down step %0d: got q=%h done=%b expected q=00 done=1", k, q_s2, done_s2); end
        end
        enable = 0;
        step();
        checks++; if (done_s2 !== 1'b0) begin errors++; $display("FAIL sat_idle_done: got %b expected 0", done_s2); end
    endtask

    task automatic test_priority();
        clear = 1; load = 1; enable = 1; up_dn = 1; load_val = 16'h0037;
        step();
        checks++; if (q_w2 !== 8'h00) begin errors++; $display("FAIL prio_clear: got %h expected 00", q_w2); end
        clear = 0;
        step();
        checks++; if (q_w2 !== 8'h37) begin errors++; $display("FAIL prio_load: got %h expected 37", q_w2); end
        load_val = 16'h00A5;
        step();
        checks++; if (q_w2 !== 8'h05) begin errors++; $display("FAIL bad_load_q: got %h expected 05", q_w2); end
        checks++; if (err_w2 !== 1'b1) begin errors++; $display("FAIL bad_load_err: got %b expected 1", err_w2); end
        load = 0; enable = 0;
        step();
        checks++; if (err_w2 !== 1'b0 || q_w2 !== 8'h05) begin errors++; $display("FAIL bad_load_after: got err=%b q=%h expected err=0 q=05", err_w2, q_w2); end
    endtask

    task automatic test_async_reset();
        load = 1; load_val = 16'h0041;
        step();
        load = 0; enable = 1; up_dn = 1;
        step();
        checks++; if (q_w2 !== 8'h42) begin errors++; $display("FAIL arst_pre: got %h expected 42", q_w2); end
        #3;
        reset = 1;
        zero_models();
        #1;
        checks++; if (q_w2 !== 8'h00 || done_w2 !== 1'b0) begin errors++; $display("FAIL arst_immediate: got q=%h done=%b expected q=00 done=0", q_w2, done_w2); end
        checks++; if (q_w4 !== 16'h0000) begin errors++; $display("FAIL arst_w4: got %h expected 0000", q_w4); end
        @(posedge clk);
        #1;
        checks++; if (q_w2 !== 8'h00) begin errors++; $display("FAIL arst_held: got %h expected 00", q_w2); end
        #2;
        reset = 0;
        step();
        checks++; if (q_w2 !== 8'h01) begin errors++; $display("FAIL arst_resume: got %h expected 01", q_w2); end
        enable = 0;
    endtask

    task automatic test_digits4();
        load = 1; load_val = 16'h0999;
        step();
        load = 0; enable = 1; up_dn = 1;
        step();
        checks++; if (q_w4 !== 16'h1000 || done_w4 !== 1'b0) begin errors++; $display("FAIL d4_carry: got q=%h done=%b expected q=1000 done=0", q_w4, done_w4); end
        load = 1; enable = 0; load_val = 16'h9999;
        step();
        load = 0; enable = 1;
        step();
        checks++; if (q_w4 !== 16'h0000 || done_w4 !== 1'b1) begin errors++; $display("FAIL d4_wrap: got q=%h done=%b expected q=0000 done=1", q_w4, done_w4); end
        enable = 0;
        step();
        checks++; if (done_w4 !== 1'b0) begin errors++; $display("FAIL d4_pulse: got %b expected 0", done_w4); end
    endtask

    task automatic test_random();
        logic [15:0] e;
        for (int c = 0; c < 1000; c++) begin
            enable = ($urandom_range(0, 3) != 0);
            up_dn  = $urandom_range(0, 1);
            clear  = ($urandom_range(0, 63) == 0);
            load   = ($urandom_range(0, 19) == 0);
            case ($urandom_range(0, 5))
                0: load_val = 16'($urandom);
                1: load_val = 16'h9999;
                2: load_val = 16'h0000;
                default:
                    for (int i = 0; i < 4; i++) load_val[4*i +: 4] = 4'($urandom_range(0, 9));
            endcase
            step();
            e = to_bcd(m_w2);
            checks++; if (q_w2 !== e[7:0]) begin errors++; $display("FAIL rnd_q_w2 cyc %0d: got %h expected %h", c, q_w2, e[7:0]); end
            e = to_bcd(m_s2);
            checks++; if (q_s2 !== e[7:0]) begin errors++; $display("FAIL rnd_q_s2 cyc %0d: got %h expected %h", c, q_s2, e[7:0]); end
            e = to_bcd(m_w4);
            checks++; if (q_w4 !== e) begin errors++; $display("FAIL rnd_q_w4 cyc %0d: got %h expected %h", c, q_w4, e); end
            checks++; if ({done_w2, done_s2, done_w4} !== {d_w2, d_s2, d_w4}) begin errors++; $display("FAIL rnd_done cyc %0d: got %b expected %b", c, {done_w2, done_s2, done_w4}, {d_w2, d_s2, d_w4}); end
            checks++; if ({err_w2, err_s2, err_w4} !== {e_w2, e_s2, e_w4}) begin errors++; $display("FAIL rnd_err cyc %0d: got %b expected %b", c, {err_w2, err_s2, err_w4}, {e_w2, e_s2, e_w4}); end
        end
        enable = 0; clear = 0; load = 0;
    endtask

    initial begin
        test_reset();
        test_count_up();
        test_load_down();
        test_saturate();
        test_priority();
        test_async_reset();
        test_digits4();
        test_random();
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
